// File: rtl/rc4_prga_engine.sv
// RC4 keystream generator and decryptor: walks the S-box held in an external
// single-port RAM, XORs each keystream byte with the ciphertext ROM and writes
// the plaintext RAM, optionally checking every byte against a lowercase/space
// alphabet and stopping at the first byte outside it.
module rc4_prga_engine #(
   parameter int unsigned MSG_LEN     = 32,
   parameter int unsigned MEM_LAT     = 2,
   parameter int unsigned CHECK_ASCII = 1,
   localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [7:0]    s_addr,
   output logic [7:0]    s_wdata,
   output logic          s_wren,
   input  logic [7:0]    s_rdata,
   output logic [AW-1:0] e_addr,
   input  logic [7:0]    e_rdata,
   output logic [AW-1:0] d_addr,
   output logic [7:0]    d_wdata,
   output logic          d_wren,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW-1:0] fail_idx
);

   localparam int unsigned CW = 3;

   typedef enum logic [3:0] {
      IDLE, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_SI, WR_SJ,
      RD_F, WAIT_F, RD_E, WAIT_E, WR_D, NEXT, FINISH
   } state_t;

   state_t        state, state_n;
   logic [7:0]    i, i_n, j, j_n, si, si_n, sj, sj_n, kb, kb_n;
   logic [AW-1:0] k, k_n;
   logic          fail, fail_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          last_wait;

   logic [7:0]    s_addr_n, s_wdata_n, d_wdata_n;
   logic          s_wren_n, d_wren_n, busy_n, done_n, pass_n;
   logic [AW-1:0] e_addr_n, d_addr_n, fail_idx_n;

   // Accepted output alphabet: space and lowercase letters.
   function automatic logic is_ascii(input logic [7:0] b);
      return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
   endfunction

   // Next-state and next-output logic; every output is the registered copy.
   always_comb begin
      state_n    = state;
      i_n        = i;
      j_n        = j;
      k_n        = k;
      si_n       = si;
      sj_n       = sj;
      kb_n       = kb;
      fail_n     = fail;
      cnt_n      = '0;
      s_addr_n   = s_addr;
      s_wdata_n  = s_wdata;
      s_wren_n   = 1'b0;
      e_addr_n   = e_addr;
      d_addr_n   = d_addr;
      d_wdata_n  = d_wdata;
      d_wren_n   = 1'b0;
      pass_n     = pass;
      fail_idx_n = fail_idx;
      last_wait  = (cnt == CW'(MEM_LAT - 1));

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n    = RD_SI;
               i_n        = 8'd1;
               j_n        = 8'd0;
               k_n        = '0;
               fail_n     = 1'b0;
               pass_n     = 1'b0;
               fail_idx_n = '0;
            end
         end
         RD_SI: begin
            s_addr_n = i;
            state_n  = WAIT_SI;
         end
         WAIT_SI: begin
            if (last_wait) begin
               si_n    = s_rdata;
               state_n = RD_SJ;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RD_SJ: begin
            j_n      = j + si;
            s_addr_n = j + si;
            state_n  = WAIT_SJ;
         end
         WAIT_SJ: begin
            if (last_wait) begin
               sj_n      = s_rdata;
               s_addr_n  = i;
               s_wdata_n = s_rdata;
               s_wren_n  = 1'b1;
               state_n   = WR_SI;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WR_SI: begin
            s_addr_n  = j;
            s_wdata_n = si;
            s_wren_n  = 1'b1;
            state_n   = WR_SJ;
         end
         WR_SJ: begin
            state_n = RD_F;
         end
         RD_F: begin
            s_addr_n = si + sj;
            state_n  = WAIT_F;
         end
         WAIT_F: begin
            if (last_wait) begin
               kb_n    = s_rdata;
               state_n = RD_E;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RD_E: begin
            e_addr_n = k;
            state_n  = WAIT_E;
         end
         WAIT_E: begin
            if (last_wait) begin
               d_addr_n  = k;
               d_wdata_n = kb ^ e_rdata;
               d_wren_n  = 1'b1;
               state_n   = WR_D;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WR_D: begin
            if ((CHECK_ASCII != 0) && !is_ascii(d_wdata)) begin
               fail_n     = 1'b1;
               fail_idx_n = k;
            end
            state_n = NEXT;
         end
         NEXT: begin
            i_n = i + 8'd1;
            k_n = k + AW'(1);
            if (fail || (k == AW'(MSG_LEN - 1))) begin
               pass_n  = ~fail;
               state_n = FINISH;
            end else begin
               state_n = RD_SI;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
      done_n = (state_n == FINISH);
   end

   // State, datapath and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         si       <= '0;
         sj       <= '0;
         kb       <= '0;
         fail     <= 1'b0;
         cnt      <= '0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_wren   <= 1'b0;
         e_addr   <= '0;
         d_addr   <= '0;
         d_wdata  <= '0;
         d_wren   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_idx <= '0;
      end else begin
         state    <= state_n;
         i        <= i_n;
         j        <= j_n;
         k        <= k_n;
         si       <= si_n;
         sj       <= sj_n;
         kb       <= kb_n;
         fail     <= fail_n;
         cnt      <= cnt_n;
         s_addr   <= s_addr_n;
         s_wdata  <= s_wdata_n;
         s_wren   <= s_wren_n;
         e_addr   <= e_addr_n;
         d_addr   <= d_addr_n;
         d_wdata  <= d_wdata_n;
         d_wren   <= d_wren_n;
         busy     <= busy_n;
         done     <= done_n;
         pass     <= pass_n;
         fail_idx <= fail_idx_n;
      end
   end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: memory models around the engine, a plain RC4
// reference model, per-cycle checking of writes/busy/done, and literal pins.
module tb_rc4_prga_engine;

   localparam int unsigned MSG_LEN = 12;
   localparam int unsigned MEM_LAT = 2;
   localparam int unsigned AW      = 4;
   localparam int unsigned PER_B   = 8 + 4 * MEM_LAT;

   logic          clk, rst, start;
   logic [7:0]    s_addr, s_wdata, s_rdata, e_rdata, d_wdata;
   logic          s_wren, d_wren, busy, done, pass;
   logic [AW-1:0] e_addr, d_addr, fail_idx;

   rc4_prga_engine #(.MSG_LEN(MSG_LEN), .MEM_LAT(MEM_LAT), .CHECK_ASCII(1)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
      .e_addr(e_addr), .e_rdata(e_rdata),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
      .busy(busy), .done(done), .pass(pass), .fail_idx(fail_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories: registered address plus combinational lookup gives a 2-cycle read.
   logic [7:0] s_mem [256];
   logic [7:0] s_img [256];
   logic [7:0] e_rom [16];
   logic [7:0] d_mem [16];
   logic       d_wr  [16];
   logic [7:0] s_d1;
   logic [AW-1:0] e_d1;
   logic       load;

   always @(posedge clk) begin
      s_d1 <= s_addr;
      e_d1 <= e_addr;
      if (load) begin
         s_mem <= s_img;
         for (int n = 0; n < 16; n++) d_wr[n] <= 1'b0;
      end else if (s_wren) begin
         s_mem[s_addr] <= s_wdata;
      end
      if (d_wren) begin
         d_mem[d_addr] <= d_wdata;
         d_wr[d_addr]  <= 1'b1;
      end
   end

   assign s_rdata = s_mem[s_d1];
   assign e_rdata = e_rom[e_d1];

   // Reference model state.
   logic [7:0]  ms [256];
   logic [7:0]  ks [MSG_LEN];
   logic [7:0]  d_exp [MSG_LEN];
   logic [15:0] wq [$];
   int          exp_done, exp_fail, nbytes;
   bit          exp_pass;

   int passed, total;
   int cyc, obs_done, s_seen, d_next;
   bit run_active;
   logic [7:0] lit_ks [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
   string txt = "attackatdawn";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit is_ascii(input logic [7:0] b);
      return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
   endfunction

   // Textbook RC4 PRGA on a copy of s_img; chk enables the stop-on-bad-byte rule.
   task automatic model(input bit chk_en);
      int ii, jj, a, b;
      logic [7:0] t;
      ms = s_img;
      wq.delete();
      ii = 0; jj = 0;
      exp_pass = 1'b1; exp_fail = 0; nbytes = MSG_LEN;
      for (int n = 0; n < MSG_LEN; n++) begin
         ii = (ii + 1) % 256;
         jj = (jj + int'(ms[ii])) % 256;
         wq.push_back({8'(ii), ms[jj]});
         wq.push_back({8'(jj), ms[ii]});
         t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
         a = int'(ms[ii]); b = int'(ms[jj]);
         ks[n] = ms[(a + b) % 256];
         d_exp[n] = ks[n] ^ e_rom[n];
         if (chk_en && !is_ascii(d_exp[n])) begin
            exp_pass = 1'b0; exp_fail = n; nbytes = n + 1;
            break;
         end
      end
      exp_done = nbytes * PER_B + 1;
   endtask

   task automatic ksa_key();
      logic [7:0] key [3] = '{8'h4B, 8'h65, 8'h79};
      logic [7:0] t;
      int jj;
      for (int n = 0; n < 256; n++) s_img[n] = 8'(n);
      jj = 0;
      for (int n = 0; n < 256; n++) begin
         jj = (jj + int'(s_img[n]) + int'(key[n % 3])) % 256;
         t = s_img[n]; s_img[n] = s_img[jj]; s_img[jj] = t;
      end
   endtask

   task automatic shuffle_s();
      logic [7:0] t;
      int r;
      for (int n = 0; n < 256; n++) s_img[n] = 8'(n);
      for (int n = 255; n > 0; n--) begin
         r = $urandom_range(0, n);
         t = s_img[n]; s_img[n] = s_img[r]; s_img[r] = t;
      end
   endtask

   // Ciphertext that decodes to random valid text, optionally with one bad byte.
   task automatic build_e(input bit inject);
      int r, bad;
      logic [7:0] c;
      for (int n = 0; n < 16; n++) e_rom[n] = 8'h00;
      for (int n = 0; n < MSG_LEN; n++) begin
         r = $urandom_range(0, 26);
         c = (r == 26) ? 8'h20 : 8'(8'h61 + r);
         e_rom[n] = ks[n] ^ c;
      end
      if (inject) begin
         bad = $urandom_range(0, MSG_LEN - 1);
         e_rom[bad] = ks[bad] ^ 8'h41;
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the edge.
   task automatic cycle();
      logic [15:0] w;
      @(posedge clk);
      #1;
      cyc++;
      if (run_active) begin
         chk("one_wren", 32'(s_wren & d_wren), 32'd0);
         chk("busy", 32'(busy), 32'(cyc <= exp_done));
         chk("done", 32'(done), 32'(cyc == exp_done));
         if (done) begin
            obs_done = cyc;
            chk("pass", 32'(pass), 32'(exp_pass));
            if (!exp_pass) chk("fail_idx", 32'(fail_idx), 32'(exp_fail));
         end
         if (s_wren) begin
            s_seen++;
            if (wq.size() > 0) begin
               w = wq.pop_front();
               chk("s_write", 32'({s_addr, s_wdata}), 32'(w));
            end
         end
         if (d_wren) begin
            if (d_next < MSG_LEN) begin
               chk("d_addr", 32'(d_addr), 32'(d_next));
               chk("d_data", 32'(d_wdata), 32'(d_exp[d_next]));
            end
            d_next++;
         end
      end
   endtask

   task automatic load_s();
      load = 1'b1;
      cycle();
      load = 1'b0;
   endtask

   // Runs one transaction from the next edge; abort_at>0 stops early in that cycle.
   task automatic do_run(input bit pulses, input bit chain, input int abort_at);
      int limit, nw, mism;
      nw = wq.size();
      s_seen = 0; d_next = 0; obs_done = 0; cyc = 0;
      run_active = 1'b1;
      start = 1'b1;
      limit = (abort_at > 0) ? abort_at : exp_done + 1;
      while (cyc < limit) begin
         cycle();
         if (cyc < exp_done)       start = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
         else if (cyc == exp_done) start = pulses | chain;
         else                      start = chain;
      end
      run_active = 1'b0;
      if (abort_at == 0) begin
         chk("s_write_count", 32'(s_seen), 32'(nw));
         chk("d_write_count", 32'(d_next), 32'(nbytes));
         chk("done_cycle", 32'(obs_done), 32'(exp_done));
         mism = 0;
         for (int n = 0; n < 256; n++) if (s_mem[n] !== ms[n]) mism++;
         chk("s_final", 32'(mism), 32'd0);
      end
   endtask

   initial begin
      passed = 0; total = 0; cyc = 0; run_active = 1'b0;
      rst = 1'b1; start = 1'b0; load = 1'b0;
      for (int n = 0; n < 16; n++) e_rom[n] = 8'h00;
      for (int n = 0; n < 256; n++) s_img[n] = 8'(n);

      // Reset state.
      cycle(); cycle();
      chk("rst_s_addr", 32'(s_addr), 0);     chk("rst_s_wdata", 32'(s_wdata), 0);
      chk("rst_s_wren", 32'(s_wren), 0);     chk("rst_e_addr", 32'(e_addr), 0);
      chk("rst_d_addr", 32'(d_addr), 0);     chk("rst_d_wdata", 32'(d_wdata), 0);
      chk("rst_d_wren", 32'(d_wren), 0);     chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);         chk("rst_pass", 32'(pass), 0);
      chk("rst_fail_idx", 32'(fail_idx), 0);
      rst = 1'b0;
      cycle();

      // Identity S, zero ciphertext: first byte 0x02 is rejected at index 0.
      for (int n = 0; n < 256; n++) s_img[n] = 8'(n);
      model(1'b1);
      load_s();
      do_run(1'b0, 1'b0, 0);
      chk("id_d0", 32'(d_mem[0]), 32'h02);
      chk("id_d1_unwritten", 32'(d_wr[1]), 0);
      chk("id_d3_unwritten", 32'(d_wr[3]), 0);
      chk("id_s1", 32'(s_mem[1]), 32'd1);
      chk("id_done_cycle", 32'(obs_done), 32'd17);
      chk("id_pass", 32'(pass), 0);
      chk("id_fail_idx", 32'(fail_idx), 0);

      // KSA("Key") with ciphertext of "attackatdawn".
      ksa_key();
      model(1'b0);
      for (int n = 0; n < 9; n++) chk("model_keystream", 32'(ks[n]), 32'(lit_ks[n]));
      for (int n = 0; n < MSG_LEN; n++)
         e_rom[n] = ((n < 9) ? lit_ks[n] : ks[n]) ^ 8'(txt[n]);
      model(1'b1);
      load_s();
      do_run(1'b0, 1'b0, 0);
      for (int n = 0; n < MSG_LEN; n++) chk("key_text", 32'(d_mem[n]), 32'(txt[n]));
      chk("key_done_cycle", 32'(obs_done), 32'd193);
      chk("key_pass", 32'(pass), 32'd1);

      // Reset during WR_SJ of byte 3 (cycle 3*16+8), then a clean rerun.
      model(1'b1);
      load_s();
      do_run(1'b0, 1'b0, 56);
      chk("pre_rst_s_wren", 32'(s_wren), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_s_wren", 32'(s_wren), 0);
      chk("async_rst_busy", 32'(busy), 0);
      cycle(); cycle();
      rst = 1'b0;
      model(1'b1);
      load_s();
      do_run(1'b0, 1'b0, 0);
      for (int n = 0; n < MSG_LEN; n++) chk("rerun_text", 32'(d_mem[n]), 32'(txt[n]));

      // Random S boxes and ciphertexts, with start pulses during some runs.
      for (int r = 0; r < 6; r++) begin
         shuffle_s();
         model(1'b0);
         build_e(1'($urandom_range(0, 1)));
         model(1'b1);
         load_s();
         do_run(1'($urandom_range(0, 1)), 1'b0, 0);
      end

      // Start held through FINISH into IDLE: second run starts fresh on the swapped S.
      shuffle_s();
      model(1'b0);
      build_e(1'b0);
      model(1'b1);
      load_s();
      do_run(1'b1, 1'b1, 0);
      s_img = s_mem;
      model(1'b0);
      build_e(1'b0);
      model(1'b1);
      do_run(1'b0, 1'b0, 0);
      chk("chain_pass", 32'(pass), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rc4_prga_engine.md
RC4_PRGA_ENGINE -- requirements
Module: rc4_prga_engine

Interface
REQ-001 Parameter MSG_LEN, default 32: message length in bytes, range 1..256.
REQ-002 Parameter MEM_LAT, default 2: read latency of all three memories in cycles, range 1..4.
REQ-003 Parameter CHECK_ASCII, default 1: when 1, each output byte is checked against {0x20, 0x61..0x7A}; when 0, the check is disabled.
REQ-004 Derived AW = max(1, clog2(MSG_LEN)): width of the message index.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  run request; sampled only in IDLE.
REQ-008 s_addr  out  8  S-RAM (256x8, single-port) address.
REQ-009 s_wdata  out  8  S-RAM write data.
REQ-010 s_wren  out  1  S-RAM write enable.
REQ-011 s_rdata  in  8  S-RAM read data.
REQ-012 e_addr  out  AW  ciphertext ROM address.
REQ-013 e_rdata  in  8  ciphertext ROM data.
REQ-014 d_addr  out  AW  plaintext RAM address.
REQ-015 d_wdata  out  8  plaintext RAM write data.
REQ-016 d_wren  out  1  plaintext RAM write enable.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 pass  out  1  result flag; valid while done is high, held until the next start.
REQ-020 fail_idx  out  AW  index of the first failing byte; valid with pass=0.

Function
REQ-021 Indices: i (8b), j (8b), k (AW). Every accepted start loads i=1, j=0, k=0, pass=0 and fail_idx=0.
REQ-022 State sequence: IDLE -> RD_SI -> WAIT_SI -> RD_SJ -> WAIT_SJ -> WR_SI -> WR_SJ -> RD_F -> WAIT_F -> RD_E -> WAIT_E -> WR_D -> NEXT -> (RD_SI | FINISH) -> IDLE.
REQ-023 Addresses are registered: s_addr or e_addr updates at the end of the RD_x state.
REQ-024 Each WAIT_x state lasts exactly MEM_LAT cycles; read data is captured on the last WAIT_x cycle.
REQ-025 WAIT_SI captures si = S[i]; RD_SJ computes j = (j + si) mod 256; WAIT_SJ captures sj = S[j].
REQ-026 WR_SI writes S[i] = sj, with s_wren high for 1 cycle.
REQ-027 WR_SJ writes S[j] = si, with s_wren high for 1 cycle.
REQ-028 When i==j, both swap writes still occur; the final contents equal the original.
REQ-029 The swap is write-only; the engine never reads back to confirm a write.
REQ-030 RD_F addresses f = (si + sj) mod 256; WAIT_F captures kb = S[f].
REQ-031 RD_E addresses e[k]; WAIT_E captures eb.
REQ-032 WR_D writes d[k] = kb XOR eb, with d_wren high for 1 cycle.
REQ-033 When CHECK_ASCII=1 and the byte written in WR_D is outside {0x20, 0x61..0x7A}, WR_D sets a fail flag and latches fail_idx = k; the byte is still written.
REQ-034 NEXT increments i (255 wraps to 0) and k.
REQ-035 NEXT goes to FINISH when fail is set or k == MSG_LEN-1; otherwise it goes to RD_SI.
REQ-036 In FINISH: done=1; pass=1 only if no byte failed. FINISH always returns to IDLE.
REQ-037 Per-byte cost is exactly 8 + 4*MEM_LAT cycles.
REQ-038 On a full run, done is high in cycle MSG_LEN*(8+4*MEM_LAT)+1 counted after the start edge.
REQ-039 On an abort at index n, done is high in cycle (n+1)*(8+4*MEM_LAT)+1 counted after the start edge.
REQ-040 start is ignored while busy=1.
REQ-041 start high in the FINISH cycle is ignored; start high in the following IDLE cycle is accepted.
REQ-042 Only one write enable is high in any cycle.
REQ-043 Write enables are high only in WR_SI, WR_SJ and WR_D.
REQ-044 The S-RAM is never written outside WR_SI and WR_SJ.

Reset
REQ-045 While rst=1: state=IDLE, all indices and data registers 0, all addresses 0, s_wdata and d_wdata 0.
REQ-046 While rst=1: s_wren, d_wren, busy, done, pass and fail_idx are all 0.
REQ-047 rst asserted mid-run deasserts both write enables immediately (asynchronously) and abandons the run; the next start begins fresh per REQ-021.

Verification
REQ-048 S identity (S[x]=x), e all 0x00, MSG_LEN=4, CHECK_ASCII=1, MEM_LAT=2 -> d[0]=0x02, S[1]=1 unchanged, done in cycle 17, pass=0, fail_idx=0, d[1..3] unwritten.
REQ-049 S preloaded with KSA("Key"), e = BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9, CHECK_ASCII=0 -> d = 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), pass=1, done in cycle 145.
REQ-050 Same S, e = keystream XOR "attackatdawn" (12 bytes), CHECK_ASCII=1 -> d = "attackatdawn", pass=1.
REQ-051 Repeat REQ-049 with MEM_LAT=1 and with MEM_LAT=4 -> identical d and S contents; done in cycles 109 and 217 respectively.
REQ-052 Assert rst during WR_SJ of byte 3 -> s_wren=0 in the same cycle; then reload S and start -> a run identical to REQ-049.
REQ-053 Pulse start repeatedly during a run and in the FINISH cycle -> no restart and no second done; start in the following IDLE cycle -> a new run with i=1, j=0.
